pwm_deadtime_modulator: RTL
===========================

# pwm_deadtime_modulator

Consumer of the triangular carrier counters. Compares a carrier value against a shadow-latched duty reference and drives one complementary half-bridge gate pair with programmable dead time. One instance per inverter leg. Legs on the 0° carrier and legs on the 180° carrier share this block unchanged.

## Interface
- WIDTH_TRIANG, 7: carrier and duty width; carrier range is 0..2^WIDTH_TRIANG-1.
- DEADTIME_W, 4: dead-time count width.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- carrier  in  WIDTH_TRIANG  triangle count from the carrier generator.
- duty  in  WIDTH_TRIANG  requested duty compare value.
- deadtime  in  DEADTIME_W  dead-time length in clk cycles.
- enable  in  1  leg enable, level-sensitive.
- gate_hi  out  1  high-side gate, registered.
- gate_lo  out  1  low-side gate, registered.
- sync  out  1  one-cycle pulse on the cycle duty_sh reloads.

## Operation
- Reset values:
  - gate_hi, gate_lo, sync = 0.
  - duty_sh = 0, pwm_raw = 0, dead counter = 0.
  - FSM = IDLE.
- Shadow duty:
  - duty_sh loads duty at the edge where carrier == 0 or carrier == 2^WIDTH_TRIANG-1.
  - sync = 1 in the following cycle.
  - duty changes at any other time have no effect until the next extreme.
- Compare: pwm_raw <= (duty_sh == 2^WIDTH_TRIANG-1) ? 1 : (carrier < duty_sh).
  - duty 0 gives a constant low.
  - Full-scale duty gives a constant high.
- FSM states: IDLE, LO, DEAD_LH, HI, DEAD_HL. Gate decode:
  - HI: gate_hi = 1.
  - LO: gate_lo = 1.
  - IDLE, DEAD_LH, DEAD_HL: both gates 0.
- Transitions:
  - IDLE -> LO when enable = 1.
  - LO -> DEAD_LH when pwm_raw = 1 and deadtime != 0; the counter loads deadtime-1.
  - LO -> HI when pwm_raw = 1 and deadtime == 0.
  - DEAD_LH -> HI when the counter reaches 0 and pwm_raw = 1; otherwise the counter decrements.
  - DEAD_LH -> LO when pwm_raw = 0 (aborted edge); the counter clears.
  - HI -> DEAD_HL and HI -> LO mirror the LO transitions, triggered on pwm_raw = 0.
  - DEAD_HL -> LO and abort back to HI mirror the DEAD_LH transitions.
  - Any state -> IDLE when enable = 0. This has priority over every other transition.
- deadtime is sampled only on entry to a dead state. Changing it mid-dead has no effect on the count in progress.
- Invariant: gate_hi & gate_lo never both 1, in any state and during reset.

## Timing
- Carrier or duty_sh change at cycle k: pwm_raw updates at k+1.
- Rising edge of pwm_raw:
  - gate_lo falls at k+2.
  - gate_hi rises at k+2+D, where D = deadtime.
  - Both gates are low for exactly D cycles; D = 0 gives a direct swap at k+2.
- Falling edge of pwm_raw is symmetric.
- enable falling at cycle k: both gates are 0 from k+1.
- enable rising from IDLE: gate_lo = 1 one cycle later. gate_hi is reachable only through LO.
- rst asserted: outputs go to their reset values immediately, without waiting for a clock edge.
- First duty_sh load after reset happens at the first carrier extreme, which is immediate for the 180° generator (reset value is max).

## Configuration
- PWM_FAULT_EN defined:
  - Adds input fault (1 bit) and output fault_flag (1 bit, reset 0).
  - fault = 1 sampled at an edge sets fault_flag and forces IDLE at that same edge.
  - The FSM stays in IDLE while fault_flag = 1.
  - fault_flag clears only on an edge with enable = 0 and fault = 0.
- PWM_FAULT_EN undefined: neither port exists and behaviour is exactly as above.

## Structure
- Shared package pwm_pkg holds:
  - pwm_state_t enum (IDLE, LO, DEAD_LH, HI, DEAD_HL), with explicit 3-bit encoding.
  - Default-width localparams for carrier and dead time.
- One sub-module, pwm_dt_counter: loadable down-counter with load, clear and zero flag, DEADTIME_W wide.
- The FSM, shadow register and compare stay in the top module.

## Test plan
- Reset mid-HI: rst low asynchronously -> gate_hi = gate_lo = sync = 0 before the next edge; IDLE after release.
- Normal switching:
  - Stimulus: 180° triangle from 127, duty = 64, deadtime = 3, enable = 1.
  - Response: gate_hi high while delayed carrier < 64.
  - Response: exactly 3 both-low cycles at every transition.
  - Response: never an overlap of gate_hi and gate_lo.
- Shadow reload:
  - Stimulus: duty changes 64 -> 32 while carrier = 50 on the down-ramp.
  - Response: switching still follows 64 until carrier = 0.
  - Response: sync pulses the cycle after carrier = 0; the 32 threshold applies from then on.
- Duty extremes:
  - duty = 0 -> gate_lo constant 1.
  - duty = 127 -> gate_hi constant 1 after the first reload.
  - deadtime = 0 -> the 64-duty swap happens with no both-low cycle.
- Aborted edge:
  - Stimulus: carrier driven directly so pwm_raw is high for 2 cycles, deadtime = 5.
  - Response: gate_hi never asserts; gate_lo is low for exactly 2 cycles.
- Enable:
  - enable low while in HI -> both gates 0 next cycle.
  - enable re-asserted -> gate_lo one cycle later.
  - With PWM_FAULT_EN: fault pulse -> IDLE and fault_flag = 1; the leg stays off until enable cycles low.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared FSM state encoding and default widths for the PWM dead-time modulator.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH_TRIANG = 7;
    localparam int unsigned PWM_DEADTIME_W   = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LO      = 3'd1,
        DEAD_LH = 3'd2,
        HI      = 3'd3,
        DEAD_HL = 3'd4
    } pwm_state_t;

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable dead-time down-counter; clear has priority over load, decrement saturates at zero.
module pwm_dt_counter
    import pwm_pkg::*;
#(
    parameter int unsigned DEADTIME_W = PWM_DEADTIME_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DEADTIME_W-1:0] load_val,
    input  logic                  clear,
    input  logic                  dec,
    output logic                  zero_c
);

    logic [DEADTIME_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - DEADTIME_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/pwm_deadtime_modulator.sv
// One half-bridge leg: shadowed duty compare against the triangle carrier, complementary gates with dead time.
// Optional fault latch and forced-off behaviour enabled by defining PWM_FAULT_EN.
module pwm_deadtime_modulator
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH_TRIANG = PWM_WIDTH_TRIANG,
    parameter int unsigned DEADTIME_W   = PWM_DEADTIME_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH_TRIANG-1:0] carrier,
    input  logic [WIDTH_TRIANG-1:0] duty,
    input  logic [DEADTIME_W-1:0]   deadtime,
    input  logic                    enable,
`ifdef PWM_FAULT_EN
    input  logic                    fault,
    output logic                    fault_flag,
`endif
    output logic                    gate_hi,
    output logic                    gate_lo,
    output logic                    sync
);

    localparam logic [WIDTH_TRIANG-1:0] CARRIER_MAX = '1;

    pwm_state_t            state, state_nxt;
    logic [WIDTH_TRIANG-1:0] duty_sh;
    logic                  pwm_raw;
    logic                  extreme_c;
    logic                  force_idle_c;
    logic                  dt_nz_c;
    logic [DEADTIME_W-1:0] dt_load_val_c;
    logic                  cnt_load, cnt_clear, cnt_dec;
    logic                  cnt_zero_c;

    assign extreme_c     = (carrier == '0) || (carrier == CARRIER_MAX);
    assign dt_nz_c       = (deadtime != '0);
    assign dt_load_val_c = deadtime - DEADTIME_W'(1);

`ifdef PWM_FAULT_EN
    assign force_idle_c = !enable || fault || fault_flag;

    // Fault latch: only a disabled, fault-free edge re-arms the leg.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_flag <= 1'b0;
        end else if (fault) begin
            fault_flag <= 1'b1;
        end else if (!enable) begin
            fault_flag <= 1'b0;
        end
    end
`else
    assign force_idle_c = !enable;
`endif

    // Duty shadow reloads only at carrier extremes; compare uses the shadowed value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_sh <= '0;
            pwm_raw <= 1'b0;
            sync    <= 1'b0;
        end else begin
            sync    <= extreme_c;
            pwm_raw <= (duty_sh == CARRIER_MAX) ? 1'b1 : (carrier < duty_sh);
            if (extreme_c) begin
                duty_sh <= duty;
            end
        end
    end

    pwm_dt_counter #(
        .DEADTIME_W (DEADTIME_W)
    ) u_dt_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (dt_load_val_c),
        .clear    (cnt_clear),
        .dec      (cnt_dec),
        .zero_c   (cnt_zero_c)
    );

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        cnt_dec   = 1'b0;
        if (force_idle_c) begin
            state_nxt = IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state)
                IDLE: state_nxt = LO;
                LO: begin
                    if (pwm_raw) begin
                        state_nxt = dt_nz_c ? DEAD_LH : HI;
                        cnt_load  = dt_nz_c;
                    end
                end
                DEAD_LH: begin
                    if (!pwm_raw) begin
                        state_nxt = LO;
                        cnt_clear = 1'b1;
                    end else if (cnt_zero_c) begin
                        state_nxt = HI;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                HI: begin
                    if (!pwm_raw) begin
                        state_nxt = dt_nz_c ? DEAD_HL : LO;
                        cnt_load  = dt_nz_c;
                    end
                end
                DEAD_HL: begin
                    if (pwm_raw) begin
                        state_nxt = HI;
                        cnt_clear = 1'b1;
                    end else if (cnt_zero_c) begin
                        state_nxt = LO;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // Gates decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
        end else begin
            state   <= state_nxt;
            gate_hi <= (state_nxt == HI);
            gate_lo <= (state_nxt == LO);
        end
    end

endmodule
